cpu_step_ctrl: RTL and testbench

Run/step controller downstream of the slow-clock divider: it consumes the divider's toggling slow clock as a plain data input and turns it into single-cycle clock-enable pulses for the RV32 core. Modes are halt, slow-step, free-run and button single-step. A debounced step button and an optional PC breakpoint are included. The core stays on `clk_in`; only `core_ce` gates its progress.

---
 rtl/cpu_step_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_cpu_step_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: turns the divider's slow clock, a debounced step button and
// the selected run mode into single-cycle clock-enable pulses for the RV32 core.
// Build option: define CPU_STEP_BREAKPOINT_EN to include the PC breakpoint
// (bp_armed, S_BP, sticky bp_hit); otherwise the breakpoint ports are ignored.
module cpu_step_ctrl #(
  parameter int CNT_W        = 16,
  parameter int DEBOUNCE_CYC = 330000
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              slow_clk_in,
  input  logic [1:0]        mode,
  input  logic              step_btn,
  input  logic              bp_en,
  input  logic [31:0]       bp_addr,
  input  logic [31:0]       pc,
  output logic              core_ce,
  output logic              halted,
  output logic              bp_hit,
  output logic [CNT_W-1:0]  step_count
);

  localparam logic [1:0] M_HALT   = 2'b00;
  localparam logic [1:0] M_SLOW   = 2'b01;
  localparam logic [1:0] M_RUN    = 2'b10;
  localparam logic [1:0] M_SINGLE = 2'b11;

  localparam int             DB_W      = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DB_W-1:0] DB_RELOAD = DB_W'(DEBOUNCE_CYC - 1);

  typedef enum logic [2:0] {S_HALT, S_WAIT, S_PULSE, S_RUN, S_BP} state_t;

  state_t state;
  state_t state_next;

  // ---------------------------------------------------------------------
  // Slow clock: synchronize, then detect rising edges (one tick per period)
  // ---------------------------------------------------------------------
  logic slow_ff1, slow_ff2, slow_ff3;
  logic tick;

  // Two-flop synchronizer plus a delay flop for edge detection.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      slow_ff1 <= 1'b0;
      slow_ff2 <= 1'b0;
      slow_ff3 <= 1'b0;
    end else begin
      slow_ff1 <= slow_clk_in;
      slow_ff2 <= slow_ff1;
      slow_ff3 <= slow_ff2;
    end
  end

  assign tick = slow_ff2 & ~slow_ff3;

  // ---------------------------------------------------------------------
  // Step button: synchronize, debounce, and turn a press into a request
  // ---------------------------------------------------------------------
  logic            btn_ff1, btn_ff2;
  logic            btn_stable;
  logic [DB_W-1:0] db_cnt;
  logic            btn_rise;
  logic            step_req;
  logic            req_take;

  // The stable level only follows the synced level once it has differed
  // for DEBOUNCE_CYC consecutive cycles; any agreement reloads the count.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      btn_ff1    <= 1'b0;
      btn_ff2    <= 1'b0;
      btn_stable <= 1'b0;
      db_cnt     <= DB_RELOAD;
    end else begin
      btn_ff1 <= step_btn;
      btn_ff2 <= btn_ff1;
      if (btn_ff2 == btn_stable) begin
        db_cnt <= DB_RELOAD;
      end else if (db_cnt == '0) begin
        btn_stable <= btn_ff2;
        db_cnt     <= DB_RELOAD;
      end else begin
        db_cnt <= db_cnt - DB_W'(1);
      end
    end
  end

  // Accepted press: the stable level is about to flip from 0 to 1.
  assign btn_rise = btn_ff2 & ~btn_stable & (db_cnt == '0);

  // The FSM consumes a request when it leaves S_HALT on it in SINGLE mode.
  assign req_take = (state == S_HALT) && (mode == M_SINGLE) && step_req;

  // Pending step request; only meaningful while SINGLE mode is selected.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      step_req <= 1'b0;
    end else if (mode != M_SINGLE) begin
      step_req <= 1'b0;
    end else if (btn_rise) begin
      step_req <= 1'b1;
    end else if (req_take) begin
      step_req <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Breakpoint
  // ---------------------------------------------------------------------
  logic bp_stop;

`ifdef CPU_STEP_BREAKPOINT_EN
  logic bp_armed;

  assign bp_stop = bp_en & bp_armed & (pc == bp_addr);

  // Disarm on entering S_BP so the core can step past the breakpoint PC;
  // re-arm on the first enabled cycle after leaving.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      bp_armed <= 1'b1;
    end else if ((state_next == S_BP) && (state != S_BP)) begin
      bp_armed <= 1'b0;
    end else if (core_ce) begin
      bp_armed <= 1'b1;
    end
  end
`else
  logic unused_bp;

  assign bp_stop   = 1'b0;
  assign unused_bp = ^{bp_en, bp_addr, pc};
`endif

  // ---------------------------------------------------------------------
  // Mode FSM
  // ---------------------------------------------------------------------

  // Next-state decision; a breakpoint pre-empts every move that would
  // enable the core, regardless of mode or tick.
  always_comb begin
    state_next = state;
    case (state)
      S_HALT: begin
        if (mode == M_RUN)
          state_next = bp_stop ? S_BP : S_RUN;
        else if (mode == M_SLOW)
          state_next = S_WAIT;
        else if ((mode == M_SINGLE) && step_req)
          state_next = bp_stop ? S_BP : S_PULSE;
      end
      S_WAIT: begin
        if ((mode == M_HALT) || (mode == M_SINGLE))
          state_next = S_HALT;
        else if (mode == M_RUN)
          state_next = bp_stop ? S_BP : S_RUN;
        else if (tick)
          state_next = bp_stop ? S_BP : S_PULSE;
      end
      S_PULSE: begin
        if (mode == M_SLOW)
          state_next = S_WAIT;
        else if (mode == M_RUN)
          state_next = bp_stop ? S_BP : S_RUN;
        else
          state_next = S_HALT;
      end
      S_RUN: begin
        if (bp_stop)
          state_next = S_BP;
        else if (mode != M_RUN)
          state_next = S_HALT;
      end
      S_BP: begin
        if (mode == M_HALT)
          state_next = S_HALT;
      end
      default: state_next = S_HALT;
    endcase
  end

  // State register with outputs registered from the state being entered,
  // so core_ce is high exactly during S_PULSE/S_RUN cycles.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state      <= S_HALT;
      core_ce    <= 1'b0;
      halted     <= 1'b1;
      bp_hit     <= 1'b0;
      step_count <= '0;
    end else begin
      state   <= state_next;
      core_ce <= (state_next == S_PULSE) || (state_next == S_RUN);
      halted  <= !((state_next == S_PULSE) || (state_next == S_RUN));
`ifdef CPU_STEP_BREAKPOINT_EN
      bp_hit  <= (state_next == S_BP);
`else
      bp_hit  <= 1'b0;
`endif
      if (core_ce)
        step_count <= step_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Testbench for cpu_step_ctrl. Stimulus pushes one expected record per
// core_ce pulse; a monitor pops a record on every enabled cycle and checks
// step_count (and the cycle number where timing is fixed). Phase-end state
// checks are done by the stimulus process. Breakpoint expectations follow
// CPU_STEP_BREAKPOINT_EN.
module tb_cpu_step_ctrl;

  localparam logic [1:0] M_HALT   = 2'b00;
  localparam logic [1:0] M_SLOW   = 2'b01;
  localparam logic [1:0] M_RUN    = 2'b10;
  localparam logic [1:0] M_SINGLE = 2'b11;

  logic        clk;
  logic        rst_n;
  logic        slow_clk_in;
  logic [1:0]  mode;
  logic        step_btn;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] pc;
  logic        core_ce;
  logic        halted;
  logic        bp_hit;
  logic [15:0] step_count;

  cpu_step_ctrl #(
    .CNT_W        (16),
    .DEBOUNCE_CYC (8)
  ) dut (
    .clk_in      (clk),
    .rst_n       (rst_n),
    .slow_clk_in (slow_clk_in),
    .mode        (mode),
    .step_btn    (step_btn),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .pc          (pc),
    .core_ce     (core_ce),
    .halted      (halted),
    .bp_hit      (bp_hit),
    .step_count  (step_count)
  );

  // Model core: one 4-byte instruction per enabled cycle; its PC already
  // points past the instruction currently being enabled.
  assign pc = {14'b0, step_count + 16'(core_ce), 2'b00};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string name;
    int    cnt;
    int    cyc;
  } exp_t;

  exp_t exp_q[$];
  int   exp_cnt  = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input string name, input int at_cyc);
    exp_t r;
    r.name = name;
    r.cnt  = exp_cnt;
    r.cyc  = at_cyc;
    exp_q.push_back(r);
    exp_cnt++;
  endtask

  task automatic check_drained(input string name);
    check({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // Monitor: every enabled cycle must match the next expected pulse.
  initial begin
    exp_t r;
    forever begin
      @(negedge clk);
      if (core_ce !== 1'b0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ce: got core_ce=%b at cyc %0d step_count=%0d, expected no pulse",
                   core_ce, cyc, step_count);
        end else begin
          r = exp_q.pop_front();
          check({r.name, "_cnt"}, 64'(step_count), 64'(r.cnt));
          if (r.cyc >= 0)
            check({r.name, "_cyc"}, 64'(cyc), 64'(r.cyc));
          $display("ce pulse %s: cyc=%0d step_count=%0d pc=0x%0h", r.name, cyc, step_count, pc);
        end
      end
    end
  end

  // Called on a negedge: reset for one edge, then check reset values.
  task automatic do_reset(input string tag);
    rst_n       = 1'b0;
    mode        = M_HALT;
    slow_clk_in = 1'b0;
    step_btn    = 1'b0;
    bp_en       = 1'b0;
    bp_addr     = 32'h0;
    @(negedge clk);
    check({tag, "_ce"},     64'(core_ce),    64'd0);
    check({tag, "_halted"}, 64'(halted),     64'd1);
    check({tag, "_bp_hit"}, 64'(bp_hit),     64'd0);
    check({tag, "_count"},  64'(step_count), 64'd0);
    rst_n   = 1'b1;
    exp_cnt = 0;
    $display("reset %s done at cyc %0d", tag, cyc);
  endtask

  initial begin
    rst_n       = 1'b0;
    mode        = M_HALT;
    slow_clk_in = 1'b0;
    step_btn    = 1'b0;
    bp_en       = 1'b0;
    bp_addr     = 32'h0;
    @(negedge clk);
    do_reset("rst0");

    // SLOW: slow clock toggles every 20 cycles, pulse 3 cycles after each rise
    mode = M_SLOW;
    repeat (4) @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      slow_clk_in = 1'b1;
      push("slow", cyc + 3);
      repeat (20) @(negedge clk);
      slow_clk_in = 1'b0;
      repeat (20) @(negedge clk);
    end
    mode = M_HALT;
    repeat (5) @(negedge clk);
    check("slow_count",  64'(step_count), 64'd3);
    check("slow_halted", 64'(halted),     64'd1);
    check_drained("slow");

    // SINGLE: bouncing press, hold, release, second press
    do_reset("rst1");
    mode = M_SINGLE;
    @(negedge clk);
    push("single1", -1);
    step_btn = 1'b1; @(negedge clk);
    step_btn = 1'b0; @(negedge clk);
    step_btn = 1'b1;
    repeat (20) @(negedge clk);
    step_btn = 1'b0;
    repeat (20) @(negedge clk);
    check("single1_count", 64'(step_count), 64'd1);
    push("single2", -1);
    step_btn = 1'b1;
    repeat (20) @(negedge clk);
    step_btn = 1'b0;
    repeat (20) @(negedge clk);
    mode = M_HALT;
    repeat (3) @(negedge clk);
    check("single_count",  64'(step_count), 64'd2);
    check("single_halted", 64'(halted),     64'd1);
    check_drained("single");

    // RUN for exactly 50 enabled cycles, then HALT
    do_reset("rst2");
    mode = M_RUN;
    for (int i = 0; i < 50; i++) push("run", cyc + 1 + i);
    repeat (50) @(negedge clk);
    mode = M_HALT;
    repeat (5) @(negedge clk);
    check("run_count",  64'(step_count), 64'd50);
    check("run_halted", 64'(halted),     64'd1);
    check("run_ce",     64'(core_ce),    64'd0);
    check("run_bp_hit", 64'(bp_hit),    64'd0);
    check_drained("run");

    // Breakpoint at 0x100 while running
    do_reset("rst3");
    bp_en   = 1'b1;
    bp_addr = 32'h100;
    mode    = M_RUN;
`ifdef CPU_STEP_BREAKPOINT_EN
    for (int i = 0; i < 64; i++) push("bp_run", cyc + 1 + i);
    repeat (80) @(negedge clk);
    check("bp_stop_ce",     64'(core_ce),    64'd0);
    check("bp_stop_halted", 64'(halted),     64'd1);
    check("bp_stop_hit",    64'(bp_hit),     64'd1);
    check("bp_stop_pc",     64'(pc),         64'h100);
    check("bp_stop_count",  64'(step_count), 64'd64);
    check_drained("bp_run");
    mode = M_HALT;
    repeat (3) @(negedge clk);
    check("bp_clear_hit",    64'(bp_hit), 64'd0);
    check("bp_clear_halted", 64'(halted), 64'd1);
    mode = M_RUN;
    for (int i = 0; i < 10; i++) push("bp_resume", cyc + 1 + i);
    repeat (10) @(negedge clk);
    mode = M_HALT;
    repeat (5) @(negedge clk);
    check("bp_resume_count", 64'(step_count), 64'd74);
    check("bp_resume_pc",    64'(pc),         64'h128);
    check("bp_resume_hit",   64'(bp_hit),     64'd0);
    check_drained("bp_resume");
`else
    for (int i = 0; i < 80; i++) push("nobp_run", cyc + 1 + i);
    repeat (40) @(negedge clk);
    check("nobp_mid_hit", 64'(bp_hit), 64'd0);
    repeat (40) @(negedge clk);
    mode = M_HALT;
    repeat (5) @(negedge clk);
    check("nobp_count", 64'(step_count), 64'd80);
    check("nobp_pc",    64'(pc),         64'h140);
    check("nobp_hit",   64'(bp_hit),     64'd0);
    check_drained("nobp_run");
`endif

    // Reset while in S_PULSE
    do_reset("rst4");
    mode = M_SLOW;
    repeat (4) @(negedge clk);
    slow_clk_in = 1'b1;
    push("pulse_rst", cyc + 3);
    repeat (3) @(negedge clk);
    check("pulse_before_rst_ce", 64'(core_ce), 64'd1);
    do_reset("rst_in_pulse");
    check_drained("pulse_rst");

    // Reset while in S_RUN
    mode = M_RUN;
    for (int i = 0; i < 5; i++) push("run_rst", cyc + 1 + i);
    repeat (5) @(negedge clk);
    check("run_before_rst_count", 64'(step_count), 64'd4);
    do_reset("rst_in_run");
    check_drained("run_rst");
    repeat (3) @(negedge clk);
    check("after_rst_ce", 64'(core_ce), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at cyc %0d, expected end of test", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
